// File: rtl/core_ex_lsu_bus_ctrl.sv
// core_ex_lsu_bus_ctrl: one-deep LSU request sequencer onto a valid/ready data bus.
// Waits for the bus response with a timeout and returns the raw read word plus low_addr/inst.
module core_ex_lsu_bus_ctrl #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int INST_W  = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [AW-1:0]       lsu_req_addr,
    input  logic                lsu_req_write,
    input  logic [XLEN-1:0]     lsu_req_wdata,
    input  logic [XLEN/8-1:0]   lsu_req_wmask,
    input  logic                lsu_req_unalign,
    input  logic [INST_W-1:0]   lsu_req_inst,

    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic [AW-1:0]       mem_cmd_addr,
    output logic                mem_cmd_write,
    output logic [XLEN-1:0]     mem_cmd_wdata,
    output logic [XLEN/8-1:0]   mem_cmd_wmask,

    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    input  logic                mem_rsp_err,

    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [XLEN-1:0]     lsu_rsp_rdata,
    output logic [1:0]          lsu_rsp_low_addr,
    output logic [INST_W-1:0]   lsu_rsp_inst,
    output logic [1:0]          lsu_rsp_err
);

    localparam int MW = XLEN / 8;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_BUS = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              write_q, write_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]     wmask_q, wmask_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic [TW-1:0]     timer_q, timer_d;

    // Handshake outputs are registered decodes of the next state.
    logic req_rdy_q;
    logic cmd_vld_q;
    logic rsp_vld_q;
    logic rsp_rdy_q;

    logic req_fire;
    logic cmd_fire;
    logic rsp_fire;
    logic bus_rsp;

    assign req_fire = lsu_req_valid & req_rdy_q;
    assign cmd_fire = cmd_vld_q & mem_cmd_ready;
    assign rsp_fire = rsp_vld_q & lsu_rsp_ready;
    assign bus_rsp  = mem_rsp_valid & rsp_rdy_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        inst_d  = inst_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = timer_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    addr_d  = lsu_req_addr;
                    write_d = lsu_req_write;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_write ? lsu_req_wmask : '0;
                    inst_d  = lsu_req_inst;
                    rdata_d = '0;
                    timer_d = '0;
                    if (lsu_req_unalign) begin
                        err_d   = ERR_MIS;
                        state_d = S_DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = S_CMD;
                    end
                end
            end
            S_CMD: begin
                if (cmd_fire) begin
                    timer_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                timer_d = timer_q + 1'b1;
                // A response on the timeout edge still counts as a response.
                if (bus_rsp) begin
                    rdata_d = (write_q | mem_rsp_err) ? '0 : mem_rsp_rdata;
                    err_d   = mem_rsp_err ? ERR_BUS : ERR_OK;
                    state_d = S_DONE;
                end else if (timer_q == TLAST) begin
                    rdata_d = '0;
                    err_d   = ERR_TMO;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            inst_q    <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
            timer_q   <= '0;
            req_rdy_q <= 1'b0;
            cmd_vld_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            inst_q    <= inst_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            req_rdy_q <= (state_d == S_IDLE);
            cmd_vld_q <= (state_d == S_CMD);
            rsp_vld_q <= (state_d == S_DONE);
            rsp_rdy_q <= 1'b1;
        end
    end

    assign lsu_req_ready    = req_rdy_q;

    assign mem_cmd_valid    = cmd_vld_q;
    assign mem_cmd_addr     = {addr_q[AW-1:2], 2'b00};
    assign mem_cmd_write    = write_q;
    assign mem_cmd_wdata    = wdata_q;
    assign mem_cmd_wmask    = wmask_q;

    assign mem_rsp_ready    = rsp_rdy_q;

    assign lsu_rsp_valid    = rsp_vld_q;
    assign lsu_rsp_rdata    = rdata_q;
    assign lsu_rsp_low_addr = addr_q[1:0];
    assign lsu_rsp_inst     = inst_q;
    assign lsu_rsp_err      = err_q;

endmodule

// File: tb/tb_core_ex_lsu_bus_ctrl.sv
// tb_core_ex_lsu_bus_ctrl: directed vector table, reset sequence and random
// transactions checked against a transaction-level model of the sequencer.
module tb_core_ex_lsu_bus_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr = '0;
    logic        lsu_req_write = 1'b0;
    logic [31:0] lsu_req_wdata = '0;
    logic [3:0]  lsu_req_wmask = '0;
    logic        lsu_req_unalign = 1'b0;
    logic [7:0]  lsu_req_inst = '0;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b0;
    logic [31:0] mem_cmd_addr;
    logic        mem_cmd_write;
    logic [31:0] mem_cmd_wdata;
    logic [3:0]  mem_cmd_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata = '0;
    logic        mem_rsp_err = 1'b0;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready = 1'b0;
    logic [31:0] lsu_rsp_rdata;
    logic [1:0]  lsu_rsp_low_addr;
    logic [7:0]  lsu_rsp_inst;
    logic [1:0]  lsu_rsp_err;

    int checks = 0;
    int failures = 0;

    core_ex_lsu_bus_ctrl #(
        .XLEN(32), .AW(32), .INST_W(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_write(lsu_req_write),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_req_unalign(lsu_req_unalign), .lsu_req_inst(lsu_req_inst),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_write(mem_cmd_write),
        .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wmask(mem_cmd_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_low_addr(lsu_rsp_low_addr),
        .lsu_rsp_inst(lsu_rsp_inst), .lsu_rsp_err(lsu_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        unalign;
        logic [7:0]  inst;
        int          crdy;
        int          rdly;
        logic        berr;
        logic [31:0] brdata;
        int          rrdy;
        logic [31:0] e_caddr;
        logic [3:0]  e_wmask;
        logic [31:0] e_rdata;
        logic [1:0]  e_err;
        int          e_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(
        logic [31:0] addr, logic write, logic [31:0] wdata, logic [3:0] wmask,
        logic unalign, logic [7:0] inst, int crdy, int rdly, logic berr,
        logic [31:0] brdata, int rrdy, logic [31:0] e_caddr, logic [3:0] e_wmask,
        logic [31:0] e_rdata, logic [1:0] e_err, int e_lat);
        vec_t v;
        v.addr = addr; v.write = write; v.wdata = wdata; v.wmask = wmask;
        v.unalign = unalign; v.inst = inst; v.crdy = crdy; v.rdly = rdly;
        v.berr = berr; v.brdata = brdata; v.rrdy = rrdy;
        v.e_caddr = e_caddr; v.e_wmask = e_wmask; v.e_rdata = e_rdata;
        v.e_err = e_err; v.e_lat = e_lat;
        return v;
    endfunction

    // rdly = cycle after cmd fire at which the bus answers; 0 = never.
    function automatic vec_t model(vec_t v);
        bit answered;
        answered  = (v.rdly >= 1) && (v.rdly <= TO);
        v.e_caddr = v.addr & 32'hFFFF_FFFC;
        v.e_wmask = v.write ? v.wmask : 4'h0;
        v.e_lat   = answered ? v.rdly : TO;
        if (v.unalign) begin
            v.e_err = 2'd1; v.e_rdata = 0;
        end else if (!answered) begin
            v.e_err = 2'd3; v.e_rdata = 0;
        end else begin
            v.e_err   = v.berr ? 2'd2 : 2'd0;
            v.e_rdata = (v.write || v.berr) ? 32'h0 : v.brdata;
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        bit got;
        int lat;
        int maxk;
        lsu_req_addr    = v.addr;
        lsu_req_write   = v.write;
        lsu_req_wdata   = v.wdata;
        lsu_req_wmask   = v.wmask;
        lsu_req_unalign = v.unalign;
        lsu_req_inst    = v.inst;
        lsu_req_valid   = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (lsu_req_ready) got = 1;
            step();
        end
        chk("req_accept", 64'(got), 64'd1);
        lsu_req_valid = 1'b0;
        lsu_req_addr  = $urandom;
        lsu_req_wdata = $urandom;
        lsu_req_inst  = 8'($urandom);
        lsu_req_write = 1'($urandom);
        if (v.unalign) begin
            chk("ua_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
            chk("ua_no_cmd", 64'(mem_cmd_valid), 64'd0);
        end else begin
            for (int i = 0; i <= v.crdy; i++) begin
                chk("cmd_valid", 64'(mem_cmd_valid), 64'd1);
                chk("cmd_addr", 64'(mem_cmd_addr), 64'(v.e_caddr));
                chk("cmd_write", 64'(mem_cmd_write), 64'(v.write));
                chk("cmd_wmask", 64'(mem_cmd_wmask), 64'(v.e_wmask));
                if (v.write) chk("cmd_wdata", 64'(mem_cmd_wdata), 64'(v.wdata));
                mem_cmd_ready = (i == v.crdy);
                step();
            end
            mem_cmd_ready = 1'b0;
            chk("cmd_drop", 64'(mem_cmd_valid), 64'd0);
            chk("rsp_ready", 64'(mem_rsp_ready), 64'd1);
            lat  = 0;
            maxk = (v.rdly > TO) ? v.rdly : TO;
            for (int k = 1; k <= maxk; k++) begin
                if (k == v.rdly) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = v.brdata;
                    mem_rsp_err   = v.berr;
                end
                step();
                mem_rsp_valid = 1'b0;
                mem_rsp_err   = 1'($urandom);
                mem_rsp_rdata = $urandom;
                if (lsu_rsp_valid && lat == 0) lat = k;
            end
            mem_rsp_err = 1'b0;
            chk("rsp_latency", 64'(lat), 64'(v.e_lat));
        end
        for (int i = 0; i <= v.rrdy; i++) begin
            chk("rsp_valid", 64'(lsu_rsp_valid), 64'd1);
            chk("rsp_rdata", 64'(lsu_rsp_rdata), 64'(v.e_rdata));
            chk("rsp_err", 64'(lsu_rsp_err), 64'(v.e_err));
            chk("rsp_low", 64'(lsu_rsp_low_addr), 64'(v.addr[1:0]));
            chk("rsp_inst", 64'(lsu_rsp_inst), 64'(v.inst));
            chk("busy_req_ready", 64'(lsu_req_ready), 64'd0);
            chk("done_no_cmd", 64'(mem_cmd_valid), 64'd0);
            lsu_rsp_ready = (i == v.rrdy);
            step();
        end
        lsu_rsp_ready = 1'b0;
        chk("rsp_drop", 64'(lsu_rsp_valid), 64'd0);
        chk("idle_req_ready", 64'(lsu_req_ready), 64'd1);
    endtask

    initial begin
        vec_t v;
        tbl.push_back(mkv(32'h1003, 0, 32'h0, 4'hF, 0, 8'h11, 0, 1, 0,
            32'hA1B2C3D4, 0, 32'h1000, 4'h0, 32'hA1B2C3D4, 2'd0, 1));
        tbl.push_back(mkv(32'h2002, 1, 32'h00AB0000, 4'b0100, 0, 8'h22, 3, 2, 0,
            32'hDEADBEEF, 1, 32'h2000, 4'b0100, 32'h0, 2'd0, 2));
        tbl.push_back(mkv(32'h3001, 0, 32'h0, 4'h0, 1, 8'h33, 0, 0, 0,
            32'h0, 2, 32'h3000, 4'h0, 32'h0, 2'd1, 0));
        tbl.push_back(mkv(32'h4000, 0, 32'h0, 4'h0, 0, 8'h44, 0, 0, 0,
            32'h0, 0, 32'h4000, 4'h0, 32'h0, 2'd3, 8));
        tbl.push_back(mkv(32'h4006, 0, 32'h0, 4'h0, 0, 8'h45, 1, 11, 0,
            32'h55667788, 0, 32'h4004, 4'h0, 32'h0, 2'd3, 8));
        tbl.push_back(mkv(32'h5001, 0, 32'h0, 4'h0, 0, 8'h55, 0, 1, 1,
            32'h12345678, 5, 32'h5000, 4'h0, 32'h0, 2'd2, 1));
        tbl.push_back(mkv(32'h6002, 0, 32'h0, 4'h0, 0, 8'h66, 0, 8, 0,
            32'hCAFEF00D, 0, 32'h6000, 4'h0, 32'hCAFEF00D, 2'd0, 8));
        tbl.push_back(mkv(32'h7000, 0, 32'h0, 4'h0, 0, 8'h77, 2, 7, 0,
            32'h0BADC0DE, 0, 32'h7000, 4'h0, 32'h0BADC0DE, 2'd0, 7));
        tbl.push_back(mkv(32'h8003, 1, 32'hFF000000, 4'b1000, 0, 8'h88, 0, 3, 1,
            32'h99999999, 0, 32'h8000, 4'b1000, 32'h0, 2'd2, 3));

        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(lsu_req_ready), 64'd0);
        chk("rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        chk("rst_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
        chk("rst_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        chk("rst_rdata", 64'(lsu_rsp_rdata), 64'd0);
        chk("rst_err", 64'(lsu_rsp_err), 64'd0);
        step();
        chk("rst_hold_ready", 64'(lsu_req_ready), 64'd0);
        #3 rst_n = 1'b1;
        step();
        step();
        chk("post_rst_ready", 64'(lsu_req_ready), 64'd1);
        chk("post_rst_rsp_rdy", 64'(mem_rsp_ready), 64'd1);

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset while waiting for a bus response.
        lsu_req_addr  = 32'h9000;
        lsu_req_write = 1'b0;
        lsu_req_unalign = 1'b0;
        lsu_req_valid = 1'b1;
        step();
        lsu_req_valid = 1'b0;
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(lsu_req_ready), 64'd0);
        chk("mid_rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        chk("mid_rst_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
        #3 rst_n = 1'b1;
        step();
        step();
        chk("mid_rst_idle", 64'(lsu_req_ready), 64'd1);
        chk("mid_rst_no_rsp", 64'(lsu_rsp_valid), 64'd0);
        run_txn(tbl[0]);

        for (int n = 0; n < 60; n++) begin
            v.addr    = $urandom;
            v.write   = 1'($urandom);
            v.wdata   = $urandom;
            v.wmask   = 4'($urandom);
            v.unalign = ($urandom_range(0, 9) == 0);
            v.inst    = 8'($urandom);
            v.crdy    = $urandom_range(0, 3);
            v.rdly    = $urandom_range(0, 10);
            v.berr    = ($urandom_range(0, 5) == 0);
            v.brdata  = $urandom;
            v.rrdy    = $urandom_range(0, 3);
            run_txn(model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
